// File: rtl/lsb_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_ser_pkg
//  Description : Shared sizes and FSM state type for the lowest-set-bit
//                request serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsb_ser_pkg;

    // Request mask width and the derived position width.
    localparam int N = 4;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : lsb_ser_pkg
`default_nettype wire

// File: rtl/lsb_enc.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_enc
//  Description : Combinational lowest-set-bit encoder. Returns the index of
//                the least significant set bit; returns 0 for a zero input.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_enc #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] pos_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        pos_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pos_o = i[W-1:0];
            end
        end
    end

endmodule : lsb_enc
`default_nettype wire

// File: rtl/lsb_req_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_req_serializer
//  Description : Accepts a request mask and streams out the positions of its
//                set bits, lowest first, one per out_valid/out_ready
//                handshake. Pulses done for one cycle when a batch ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_req_serializer
    import lsb_ser_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N-1:0]   in_mask,
    output logic           in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_pos,
    output logic           out_last,
    input  logic           out_ready,
    output logic           done,
    output logic [W:0]     count
);

    localparam logic [N-1:0] MASK_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W:0]   COUNT_ONE = {{W{1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [N-1:0]   mask_q,  mask_d;
    logic [W:0]     count_q, count_d;
    logic           done_q,  done_d;

    logic [N-1:0]   mask_cleared;
    logic [W-1:0]   enc_pos;

    // Single encoder on the registered mask; outputs are glitch-free from regs.
    lsb_enc #(
        .N (N),
        .W (W)
    ) u_lsb_enc (
        .req_i (mask_q),
        .pos_o (enc_pos)
    );

    assign mask_cleared = mask_q & (mask_q - MASK_ONE);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign out_pos   = enc_pos;
    // Only one bit left means this handshake finishes the batch.
    assign out_last  = (mask_cleared == '0);
    assign done      = done_q;
    assign count     = count_q;

    // Next-state: accept in IDLE, retire one bit per handshake in BUSY.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = in_mask;
                    count_d = '0;
                    if (in_mask != '0) begin
                        state_d = BUSY;
                    end else begin
                        // Empty batch completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    mask_d  = mask_cleared;
                    count_d = count_q + COUNT_ONE;
                    if (out_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, mask, count and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

endmodule : lsb_req_serializer
`default_nettype wire
